pll_rst_seq: RTL and testbench

Power-up, reset and lock sequencer for a GTP_PLL_E3-based clock wrapper. It drives the PLL power-down and reset pins, and filters the asynchronous LOCK output. It releases a synchronous active-low system reset to downstream logic only after a stable lock. Lock-acquisition timeouts are retried a bounded number of times. The block runs on the free-running reference clock that also feeds CLKIN1.

---
 rtl/pll_rst_seq_pkg.sv | 52 +++++
 rtl/sync_2ff.sv | 33 +++
 rtl/pll_rst_seq.sv | 135 +++++++++++++
 tb/tb_pll_rst_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// ============================================================================
// Module      : pll_rst_seq_pkg
// Description : State encoding, default timing constants and per-state output
//               decode for the PLL power-up / reset / lock sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_rst_seq_pkg;

    localparam int c_pwd_cycles   = 16;
    localparam int c_rst_cycles   = 64;
    localparam int c_lock_filt    = 1024;
    localparam int c_lock_timeout = 65536;
    localparam int c_retry_max    = 3;

    typedef enum logic [2:0] {
        PWD       = 3'd0,
        RST       = 3'd1,
        WAIT_LOCK = 3'd2,
        FILTER    = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    typedef struct packed {
        logic pwd;
        logic rst;
        logic sys_rst_n;
        logic fail;
    } seq_out_t;

    // Outputs are a pure function of the state being entered, so they can be
    // registered alongside the state itself.
    function automatic seq_out_t state_outputs(input state_t s);
        seq_out_t o;
        o = '{pwd: 1'b1, rst: 1'b1, sys_rst_n: 1'b0, fail: 1'b0};
        case (s)
            PWD:       o = '{pwd: 1'b1, rst: 1'b1, sys_rst_n: 1'b0, fail: 1'b0};
            RST:       o = '{pwd: 1'b0, rst: 1'b1, sys_rst_n: 1'b0, fail: 1'b0};
            WAIT_LOCK: o = '{pwd: 1'b0, rst: 1'b0, sys_rst_n: 1'b0, fail: 1'b0};
            FILTER:    o = '{pwd: 1'b0, rst: 1'b0, sys_rst_n: 1'b0, fail: 1'b0};
            RUN:       o = '{pwd: 1'b0, rst: 1'b0, sys_rst_n: 1'b1, fail: 1'b0};
            FAIL:      o = '{pwd: 1'b1, rst: 1'b1, sys_rst_n: 1'b0, fail: 1'b1};
            default:   o = '{pwd: 1'b1, rst: 1'b1, sys_rst_n: 1'b0, fail: 1'b0};
        endcase
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop single-bit synchronizer, async active-low
//               reset to 0. Reusable for any PLL status bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_rst_seq.sv
// ============================================================================
// Module      : pll_rst_seq
// Description : PLL power-down / reset / lock-filter sequencer with bounded
//               retries. Define PLL_RST_SEQ_AUTO_RELOCK_EN to re-run the reset
//               sequence on lock loss instead of latching a failure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int PWD_CYCLES   = c_pwd_cycles,
    parameter int RST_CYCLES   = c_rst_cycles,
    parameter int LOCK_FILT    = c_lock_filt,
    parameter int LOCK_TIMEOUT = c_lock_timeout,
    parameter int RETRY_MAX    = c_retry_max
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       soft_rst_i,
    output logic       pll_pwd_o,
    output logic       pll_rst_o,
    output logic       sys_rst_n_o,
    output logic       fail_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_cnt_o
);

    localparam int c_pwd_w  = $clog2(PWD_CYCLES + 1);
    localparam int c_rst_w  = $clog2(RST_CYCLES + 1);
    localparam int c_filt_w = $clog2(LOCK_FILT + 1);
    localparam int c_pr_w   = (c_pwd_w > c_rst_w) ? c_pwd_w : c_rst_w;
    localparam int c_cnt_w  = (c_pr_w > c_filt_w) ? c_pr_w : c_filt_w;
    localparam int c_to_w   = $clog2(LOCK_TIMEOUT + 1);

    logic               w_lock_s;
    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_timeout_tgt;
    seq_out_t           r_out;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [3:0]         r_retry;
    logic [3:0]         w_retry_nxt;
    logic               w_timeout;
    logic               w_filt_done;
    logic               w_enter;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock_i),
        .q_o   (w_lock_s)
    );

    assign w_timeout     = ((r_state == WAIT_LOCK) || (r_state == FILTER)) &&
                           (r_to_cnt == c_to_w'(LOCK_TIMEOUT - 1));
    assign w_filt_done   = (r_state == FILTER) && w_lock_s &&
                           (r_cnt == c_cnt_w'(LOCK_FILT));
    assign w_retry_nxt   = r_retry + 4'd1;
    assign w_timeout_tgt = (w_retry_nxt == 4'(RETRY_MAX)) ? FAIL : RST;
    // A soft restart re-enters PWD even from PWD, so it counts as an entry.
    assign w_enter       = (w_state_nxt != r_state) || soft_rst_i;

    always_comb begin
        w_state_nxt = r_state;
        if (soft_rst_i) begin
            w_state_nxt = PWD;
        end else begin
            case (r_state)
                PWD:       if (r_cnt == c_cnt_w'(PWD_CYCLES - 1)) w_state_nxt = RST;
                RST:       if (r_cnt == c_cnt_w'(RST_CYCLES - 1)) w_state_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (w_timeout)     w_state_nxt = w_timeout_tgt;
                    else if (w_lock_s) w_state_nxt = FILTER;
                end
                FILTER: begin
                    if (w_filt_done)    w_state_nxt = RUN;
                    else if (w_timeout) w_state_nxt = w_timeout_tgt;
                    else if (!w_lock_s) w_state_nxt = WAIT_LOCK;
                end
                RUN: begin
`ifdef PLL_RST_SEQ_AUTO_RELOCK_EN
                    if (!w_lock_s) w_state_nxt = RST;
`else
                    if (!w_lock_s) w_state_nxt = FAIL;
`endif
                end
                FAIL:    w_state_nxt = FAIL;
                default: w_state_nxt = PWD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= PWD;
            r_out    <= state_outputs(PWD);
            r_cnt    <= '0;
            r_to_cnt <= '0;
            r_retry  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= state_outputs(w_state_nxt);

            if (w_enter)
                r_cnt <= '0;
            else if (r_state inside {PWD, RST, FILTER})
                r_cnt <= r_cnt + 1'b1;

            // Spans WAIT_LOCK and FILTER; a filter bounce must not restart it.
            if ((r_state == RST) && (w_state_nxt == WAIT_LOCK))
                r_to_cnt <= '0;
            else if (((r_state == WAIT_LOCK) || (r_state == FILTER)) && !w_timeout)
                r_to_cnt <= r_to_cnt + 1'b1;

            if (soft_rst_i || (w_state_nxt == RUN))
                r_retry <= '0;
            else if (w_timeout && !w_filt_done)
                r_retry <= w_retry_nxt;
        end
    end

    assign pll_pwd_o   = r_out.pwd;
    assign pll_rst_o   = r_out.rst;
    assign sys_rst_n_o = r_out.sys_rst_n;
    assign fail_o      = r_out.fail;
    assign state_o     = r_state;
    assign retry_cnt_o = r_retry;

endmodule

`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
// ============================================================================
// Module      : tb_pll_rst_seq
// Description : Directed self-checking bench for pll_rst_seq with shortened
//               timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_rst_seq;

    localparam logic [2:0] c_st_pwd  = 3'd0;
    localparam logic [2:0] c_st_rst  = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_filt = 3'd3;
    localparam logic [2:0] c_st_run  = 3'd4;
    localparam logic [2:0] c_st_fail = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock_i;
    logic       soft_rst_i;
    logic       pll_pwd_o;
    logic       pll_rst_o;
    logic       sys_rst_n_o;
    logic       fail_o;
    logic [2:0] state_o;
    logic [3:0] retry_cnt_o;

    int   n_vec  = 0;
    int   n_err  = 0;
    int   edge_n = 0;
    int   base   = 0;
    logic r_bad  = 1'b0;

    pll_rst_seq #(
        .PWD_CYCLES   (4),
        .RST_CYCLES   (8),
        .LOCK_FILT    (16),
        .LOCK_TIMEOUT (100),
        .RETRY_MAX    (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock_i  (pll_lock_i),
        .soft_rst_i  (soft_rst_i),
        .pll_pwd_o   (pll_pwd_o),
        .pll_rst_o   (pll_rst_o),
        .sys_rst_n_o (sys_rst_n_o),
        .fail_o      (fail_o),
        .state_o     (state_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk)
        if (rst_n && sys_rst_n_o && (state_o != c_st_run)) r_bad <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after edge (base + t) of the current phase.
    task automatic go(input int t);
        while (edge_n < base + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic soft_pulse();
        soft_rst_i = 1'b1;
        @(posedge clk);
        #1;
        soft_rst_i = 1'b0;
        base = edge_n;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pwd"},   pll_pwd_o,   1);
        chk({tag, "_rst"},   pll_rst_o,   1);
        chk({tag, "_sys"},   sys_rst_n_o, 0);
        chk({tag, "_fail"},  fail_o,      0);
        chk({tag, "_state"}, state_o,     c_st_pwd);
        chk({tag, "_retry"}, retry_cnt_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        pll_lock_i = 1'b0;
        soft_rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");

        // Nominal lock: release reset, lock at cycle 20, RUN at cycle 40.
        rst_n = 1'b1;
        base  = edge_n;
        go(3);  chk("pwd_hold", pll_pwd_o, 1);     chk("pwd_state", state_o, c_st_pwd);
        go(4);  chk("rst_state", state_o, c_st_rst); chk("rst_pwd", pll_pwd_o, 0);
                chk("rst_rst", pll_rst_o, 1);
        go(12); chk("wait_state", state_o, c_st_wait); chk("wait_rst", pll_rst_o, 0);
        go(20); pll_lock_i = 1'b1;
        go(39); chk("pre_run_sys", sys_rst_n_o, 0); chk("pre_run_state", state_o, c_st_filt);
        go(40); chk("run_sys", sys_rst_n_o, 1);     chk("run_state", state_o, c_st_run);
                chk("run_retry", retry_cnt_o, 0);

        // Lock loss in RUN: sys_rst_n low three cycles later.
        go(50); pll_lock_i = 1'b0;
        go(52); chk("loss_sys_hold", sys_rst_n_o, 1);
        go(53); chk("loss_sys", sys_rst_n_o, 0);
`ifdef PLL_RST_SEQ_AUTO_RELOCK_EN
        chk("loss_state", state_o, c_st_rst);
        chk("loss_fail", fail_o, 0);
        chk("loss_rst", pll_rst_o, 1);
`else
        chk("loss_state", state_o, c_st_fail);
        chk("loss_fail", fail_o, 1);
        chk("loss_pwd", pll_pwd_o, 1);
        go(60); chk("fail_sticky", state_o, c_st_fail);
`endif

        // Recovery, then lock never arrives: three timeouts to FAIL.
        soft_pulse();
        chk("soft_state", state_o, c_st_pwd);
        chk("soft_fail", fail_o, 0);
        chk("soft_retry", retry_cnt_o, 0);
        go(4);   chk("seq2_rst", state_o, c_st_rst);
        go(12);  chk("seq2_wait", state_o, c_st_wait);
        go(111); chk("to1_pre_state", state_o, c_st_wait); chk("to1_pre_retry", retry_cnt_o, 0);
        go(112); chk("to1_state", state_o, c_st_rst); chk("to1_retry", retry_cnt_o, 1);
                 chk("to1_rst", pll_rst_o, 1);
        go(220); chk("to2_state", state_o, c_st_rst); chk("to2_retry", retry_cnt_o, 2);
        go(328); chk("to3_state", state_o, c_st_fail); chk("to3_retry", retry_cnt_o, 3);
                 chk("to3_fail", fail_o, 1); chk("to3_pwd", pll_pwd_o, 1);

        // Chatter: one low cycle in ten never completes the filter.
        soft_pulse();
        for (int k = 0; k < 112; k++) begin
            pll_lock_i = ((k % 10) != 9);
            go(k + 1);
        end
        chk("chat_state", state_o, c_st_rst);
        chk("chat_retry", retry_cnt_o, 1);
        pll_lock_i = 1'b1;
        go(137); chk("steady_pre_state", state_o, c_st_filt); chk("steady_pre_sys", sys_rst_n_o, 0);
        go(138); chk("steady_state", state_o, c_st_run); chk("steady_sys", sys_rst_n_o, 1);
                 chk("steady_retry", retry_cnt_o, 0);

        // Async reset while filtering.
        soft_pulse();
        go(15); chk("mid_filter", state_o, c_st_filt);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("mid");
        repeat (3) @(posedge clk);
        #1;
        chk("mid_sys_hold", sys_rst_n_o, 0);
        chk("mid_state_hold", state_o, c_st_pwd);
        chk("sys_only_in_run", r_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
